voltage_sampler: RTL
====================

Name: voltage_sampler

Overview:
- Front end that produces the supply-voltage sample stream consumed by the brownout rate detector.
- Paces ADC conversions with a start/done handshake and a programmable sample interval.
- Scales each ADC result to 8 bits and drives the detector's voltage bus and enable.
- Withholds the detector enable until the sample history is primed, and drops it on ADC fault.

Parameters:
- SAMPLE_DIV, 100: clock cycles between conversion ticks (>=4).
- ADC_W, 10: ADC result width (>=8).
- TIMEOUT, 64: maximum cycles to wait for adc_done before faulting.
- PRIME, 2: number of valid samples required before bod_en asserts (>=1).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  sampler run; low forces IDLE.
- adc_start  out  1  one-cycle conversion request pulse.
- adc_done  in  1  one-cycle pulse; adc_data valid in the same cycle.
- adc_data  in  ADC_W  conversion result.
- vol_bus  out  8  scaled voltage sample to detector; held between samples.
- bod_en  out  1  detector enable.
- sample_stb  out  1  one-cycle pulse when vol_bus takes a new value.
- adc_fault  out  1  sticky conversion-timeout flag.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, counters 0, pending tick cleared.
- Tick generator:
  - Down-counter runs only while enable=1; reloads to SAMPLE_DIV-1.
  - Tick = counter==0. First tick occurs SAMPLE_DIV cycles after enable rises.
- FSM states: IDLE, WAIT_TICK, CONVERT, WAIT_DONE, UPDATE, FAULT.
  - IDLE -> WAIT_TICK when enable=1.
  - WAIT_TICK -> CONVERT on tick or pending tick.
  - CONVERT: adc_start=1 for exactly this cycle; -> WAIT_DONE; timeout counter cleared.
  - WAIT_DONE:
    - adc_done=1 captures adc_data -> UPDATE.
    - Timeout counter reaching TIMEOUT-1 without adc_done -> FAULT.
  - UPDATE: vol_bus <= adc_data[ADC_W-1 -: 8] (truncate, no rounding); sample_stb=1; prime count saturating increment; -> WAIT_TICK.
  - FAULT: adc_fault=1, bod_en=0, vol_bus held. Stays until enable=0.
- Latency: adc_done high at edge N -> vol_bus/sample_stb valid after edge N+1.
- Values settle after posedge, so they are stable for a negedge-sampling consumer.
- bod_en: set with the PRIME-th sample_stb (same cycle); cleared in FAULT or when enable=0.
- Tick arriving outside WAIT_TICK:
  - Latched into a one-deep pending flag.
  - Further ticks while pending are dropped, with no counter.
- adc_done outside WAIT_DONE: ignored.
- enable=0 at any time, including mid-conversion:
  - Next edge: IDLE, adc_start=0, bod_en=0, adc_fault=0.
  - Prime count, pending tick and tick counter cleared; vol_bus holds its last value.
  - A late adc_done is ignored.
- Simultaneous adc_done and timeout expiry in the same cycle: adc_done wins.
- ADC_W=8: captured data passes to vol_bus unchanged.

Optional Feature:
- Macro: VSAMP_AVG_EN.
- Defined:
  - Four-entry moving average of captured samples.
  - Sum is ADC_W+2 bits; result = sum>>2, then truncated to 8 MSBs as above.
  - Entries start at 0 and are cleared on enable=0 and on reset.
  - PRIME is effectively max(PRIME,4), so bod_en waits until the window is full.
- Undefined: raw truncated sample, no history registers.

Decomposition:
- vsamp_pkg: state enum (6 states, 3-bit encoding), output width constant VOL_W=8, width helper for counters ($clog2 of SAMPLE_DIV/TIMEOUT).
- Sub-module sample_tick_gen: divider counter, enable-gated, one-cycle tick output.
- Top-level module contains the FSM, capture and averaging logic.

Test Plan:
- Normal pacing:
  - Stimulus: SAMPLE_DIV=10; ADC model answers 3 cycles after start with 10'h3FC.
  - Required: adc_start every 10 cycles; vol_bus=8'hFF one cycle after adc_done; sample_stb one cycle wide; bod_en rises on the 2nd sample_stb.
- Scaling:
  - Stimulus: adc_data 10'h2C7.
  - Required: vol_bus=8'hB1. With VSAMP_AVG_EN and inputs 0x100,0x100,0x200,0x200: vol_bus=8'h60 after the 4th sample.
- Timeout:
  - Stimulus: ADC never returns adc_done.
  - Required: adc_fault=1 exactly TIMEOUT cycles after adc_start; bod_en=0; vol_bus unchanged.
  - Then enable=0: adc_fault clears.
- Race:
  - Stimulus: adc_done on the final timeout cycle.
  - Required: sample accepted, no fault.
- Abort:
  - Stimulus: drop enable during WAIT_DONE, then pulse adc_done 2 cycles later.
  - Required: no sample_stb; vol_bus holds; bod_en=0; on re-enable, first adc_start after SAMPLE_DIV cycles.
- Slow ADC:
  - Stimulus: SAMPLE_DIV=10, ADC latency 14.
  - Required: the pending tick causes adc_start one cycle after UPDATE; the second missed tick is dropped.
- Reset:
  - Stimulus: async rst_n low mid-CONVERT.
  - Required: all outputs 0 immediately.

Source files
------------

// File: rtl/vsamp_pkg.sv
// Shared definitions for the voltage sampler: FSM state encoding, output
// width and a counter-width helper.
package vsamp_pkg;

    localparam int VOL_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        CONVERT   = 3'd2,
        WAIT_DONE = 3'd3,
        UPDATE    = 3'd4,
        FAULT     = 3'd5
    } vsamp_state_t;

    // Bits needed for a counter holding 0 .. count-1 (never less than one bit).
    function automatic int cnt_w(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Conversion pacing divider. While enable is high it counts down from
// SAMPLE_DIV-1 and raises a one-cycle tick at zero; the first tick lands
// SAMPLE_DIV cycles after enable rises. Dropping enable clears the counter.
module sample_tick_gen
    import vsamp_pkg::*;
#(
    parameter int SAMPLE_DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = cnt_w(SAMPLE_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] count_reg;
    logic          armed_reg;

    // Load on the first enabled edge, then count down and wrap at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            armed_reg <= 1'b0;
        end else if (!enable) begin
            count_reg <= '0;
            armed_reg <= 1'b0;
        end else if (!armed_reg) begin
            count_reg <= RELOAD;
            armed_reg <= 1'b1;
        end else if (count_reg == '0) begin
            count_reg <= RELOAD;
        end else begin
            count_reg <= count_reg - 1'b1;
        end
    end

    // The zero-count is only meaningful once the counter has been loaded
    assign tick = enable && armed_reg && (count_reg == '0);

endmodule

// File: rtl/voltage_sampler.sv
// Supply-voltage sampler feeding the brownout rate detector. Paces ADC
// conversions, scales results to 8 bits, primes and gates the detector
// enable, and latches a sticky fault when the ADC stops answering.
// Optional build macro VSAMP_AVG_EN: four-entry moving average of samples.
module voltage_sampler
    import vsamp_pkg::*;
#(
    parameter int SAMPLE_DIV = 100,
    parameter int ADC_W      = 10,
    parameter int TIMEOUT    = 64,
    parameter int PRIME      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic             adc_start,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] adc_data,
    output logic [VOL_W-1:0] vol_bus,
    output logic             bod_en,
    output logic             sample_stb,
    output logic             adc_fault
);

`ifdef VSAMP_AVG_EN
    // The detector must not see a partially filled averaging window
    localparam int PRIME_EFF = (PRIME > 4) ? PRIME : 4;
`else
    localparam int PRIME_EFF = PRIME;
`endif

    localparam int TW = cnt_w(TIMEOUT);
    localparam int PW = cnt_w(PRIME_EFF + 1);
    // Last WAIT_DONE cycle: the counter would reach TIMEOUT-1 on this edge
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 2);
    localparam logic [PW-1:0] PRIME_FULL = PW'(PRIME_EFF);

    vsamp_state_t     state_reg, state_next;
    logic             tick;
    logic             pending_reg;
    logic             go;
    logic             to_expire;
    logic             accept;
    logic             timed_out;
    logic [TW-1:0]    to_cnt_reg;
    logic [ADC_W-1:0] cap_reg;
    logic [PW-1:0]    prime_reg, prime_inc;
    logic [VOL_W-1:0] vol_reg, scaled;
    logic             stb_reg, bod_en_reg, fault_reg;
    logic             unused_lsbs;

    sample_tick_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(enable),
        .tick  (tick)
    );

    assign go        = tick || pending_reg;
    assign to_expire = (to_cnt_reg == TO_LAST);
    // adc_done beats a simultaneous timeout expiry
    assign accept    = (state_reg == WAIT_DONE) && adc_done;
    assign timed_out = (state_reg == WAIT_DONE) && !adc_done && to_expire;
    assign prime_inc = (prime_reg == PRIME_FULL) ? prime_reg : prime_reg + 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and the conversion request strobe
    always_comb begin
        state_next = state_reg;
        adc_start  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) state_next = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (go) state_next = CONVERT;
            end
            CONVERT: begin
                adc_start  = 1'b1;
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (adc_done) begin
                    state_next = UPDATE;
                end else if (to_expire) begin
                    state_next = FAULT;
                end
            end
            UPDATE: begin
                state_next = WAIT_TICK;
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Run control overrides everything, including a conversion in flight
        if (!enable) state_next = IDLE;
    end

    // One-deep memory for a tick that arrives while a conversion is busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= 1'b0;
        end else if (!enable || state_reg == WAIT_TICK) begin
            pending_reg <= 1'b0;
        end else if (tick) begin
            pending_reg <= 1'b1;
        end
    end

    // Conversion timeout counter, restarted at every request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_reg <= '0;
        end else if (!enable || state_reg == CONVERT) begin
            to_cnt_reg <= '0;
        end else if (state_reg == WAIT_DONE && !to_expire) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end
    end

    // Capture the ADC result in the cycle adc_done is seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_reg <= '0;
        end else if (enable && accept) begin
            cap_reg <= adc_data;
        end
    end

`ifdef VSAMP_AVG_EN
    logic [ADC_W-1:0] hist_reg [3];
    logic [ADC_W+1:0] sum;
    logic [ADC_W-1:0] avg;

    // Window = newest capture plus the three previous accepted samples
    always_comb begin
        sum = {2'b00, cap_reg} + {2'b00, hist_reg[0]}
            + {2'b00, hist_reg[1]} + {2'b00, hist_reg[2]};
    end

    assign avg         = sum[ADC_W+1:2];
    assign scaled      = avg[ADC_W-1 -: VOL_W];
    assign unused_lsbs = ^sum;

    // Sample history shifts once per published sample; empties when stopped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) hist_reg[i] <= '0;
        end else if (!enable) begin
            for (int i = 0; i < 3; i++) hist_reg[i] <= '0;
        end else if (state_reg == UPDATE) begin
            hist_reg[0] <= cap_reg;
            hist_reg[1] <= hist_reg[0];
            hist_reg[2] <= hist_reg[1];
        end
    end
`else
    assign scaled      = cap_reg[ADC_W-1 -: VOL_W];
    assign unused_lsbs = ^cap_reg;
`endif

    // Publish samples, count priming and manage the detector enable and fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vol_reg    <= '0;
            stb_reg    <= 1'b0;
            prime_reg  <= '0;
            bod_en_reg <= 1'b0;
            fault_reg  <= 1'b0;
        end else if (!enable) begin
            // vol_reg deliberately keeps the last published sample
            stb_reg    <= 1'b0;
            prime_reg  <= '0;
            bod_en_reg <= 1'b0;
            fault_reg  <= 1'b0;
        end else begin
            stb_reg <= 1'b0;
            if (state_reg == UPDATE) begin
                vol_reg   <= scaled;
                stb_reg   <= 1'b1;
                prime_reg <= prime_inc;
                if (prime_inc == PRIME_FULL) bod_en_reg <= 1'b1;
            end
            if (timed_out) begin
                fault_reg  <= 1'b1;
                bod_en_reg <= 1'b0;
            end
        end
    end

    assign vol_bus    = vol_reg;
    assign sample_stb = stb_reg;
    assign bod_en     = bod_en_reg;
    assign adc_fault  = fault_reg;

endmodule
